// File: rtl/spi_slave_param_pkg.sv
`default_nettype none
// ============================================================================
// Package     : spi_pkg
// Description : Shared FSM state encoding and command codes for the
//               parametrised SPI slave front-end.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

  // Frame-level FSM states of the slave.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4,
    WAIT_TX   = 3'd5,
    SEND      = 3'd6,
    FRAME_END = 3'd7
  } state_e;

  // Two-bit ctrl field carried at the top of every received word.
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage
`default_nettype wire

// File: rtl/spi_slave_param_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : spi_tx_serializer
// Description : Parallel-load, MSB-first shift register for MISO read data.
//               done flags the edge on which the last bit is shifted out.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_tx_serializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              shift_en_i,
  output logic              miso_o,
  output logic              done_o
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] sreg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              last_bit;

  assign last_bit = (cnt_q == CNT_W'(DATA_W - 1));
  assign miso_o   = sreg_q[DATA_W-1];
  assign done_o   = shift_en_i && last_bit;

  // Load restarts the bit count; each shift presents the next bit on MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      sreg_q <= data_i;
      cnt_q  <= '0;
    end else if (shift_en_i) begin
      sreg_q <= {sreg_q[DATA_W-2:0], 1'b0};
      if (!last_bit) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_slave_param.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_param
// Description : Parametrised SPI slave front-end. Deserialises sel+ctrl+payload
//               frames into {ctrl, payload} words and serialises read data on
//               MISO, with tx_valid timeout and frame error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic [DATA_W+1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              frame_err_o,
  output logic              busy_o
);

  localparam int RX_CNT_W = $clog2(DATA_W + 2);
  localparam int TO_CNT_W = $clog2(TX_TIMEOUT + 1);

  state_e              state_q;
  // Holds the first DATA_W+1 bits; the final bit is taken straight from MOSI.
  logic [DATA_W:0]     rx_sreg_q;
  logic [RX_CNT_W-1:0] rx_cnt_q;
  logic [TO_CNT_W-1:0] to_cnt_q;
  logic                rd_addr_seen_q;

  logic [DATA_W+1:0]   rx_word;
  logic [1:0]          rx_ctrl;
  logic                rx_last;
  logic                ctrl_ok;
  logic                in_frame;
  logic                ser_load;
  logic                ser_shift;
  logic                ser_miso;
  logic                ser_done;

  assign rx_word  = {rx_sreg_q, mosi_i};
  assign rx_ctrl  = rx_word[DATA_W+1:DATA_W];
  assign rx_last  = (rx_cnt_q == RX_CNT_W'(DATA_W + 1));
  // States in which a rising ss_n means the frame was cut short.
  assign in_frame = (state_q != IDLE) && (state_q != FRAME_END);

  assign ser_load  = (state_q == WAIT_TX) && !ss_n_i && tx_valid_i;
  assign ser_shift = (state_q == SEND) && !ss_n_i;
  assign miso_o    = (state_q == SEND) && ser_miso;
  assign busy_o    = (state_q != IDLE);

  // Ctrl legality for the shift state that is completing the frame.
  always_comb begin
    ctrl_ok = 1'b0;
    case (state_q)
      WRITE:     ctrl_ok = (rx_ctrl == CMD_WR_ADDR) || (rx_ctrl == CMD_WR_DATA);
      READ_ADD:  ctrl_ok = (rx_ctrl == CMD_RD_ADDR);
      READ_DATA: ctrl_ok = (rx_ctrl == CMD_RD_DATA);
      default:   ctrl_ok = 1'b0;
    endcase
  end

  // Frame FSM with rx shift, timeout counting and registered status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      rx_sreg_q      <= '0;
      rx_cnt_q       <= '0;
      to_cnt_q       <= '0;
      rd_addr_seen_q <= 1'b0;
      rx_data_o      <= '0;
      rx_valid_o     <= 1'b0;
      frame_err_o    <= 1'b0;
    end else begin
      rx_valid_o  <= 1'b0;
      frame_err_o <= 1'b0;
      if (in_frame && ss_n_i) begin
        // Early deselect: drop partial data, keep rd_addr_seen as is.
        state_q     <= IDLE;
        frame_err_o <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (!ss_n_i) begin
              state_q <= CHK_CMD;
            end
          end
          CHK_CMD: begin
            rx_cnt_q <= '0;
            if (mosi_i) begin
              state_q <= rd_addr_seen_q ? READ_DATA : READ_ADD;
            end else begin
              state_q <= WRITE;
            end
          end
          WRITE, READ_ADD, READ_DATA: begin
            rx_sreg_q <= rx_word[DATA_W:0];
            if (rx_last) begin
              if (ctrl_ok) begin
                rx_data_o  <= rx_word;
                rx_valid_o <= 1'b1;
                if (state_q == READ_ADD) begin
                  rd_addr_seen_q <= 1'b1;
                end
                if (state_q == READ_DATA) begin
                  to_cnt_q <= '0;
                  state_q  <= WAIT_TX;
                end else begin
                  state_q <= FRAME_END;
                end
              end else begin
                frame_err_o <= 1'b1;
                state_q     <= FRAME_END;
              end
            end else begin
              rx_cnt_q <= rx_cnt_q + 1'b1;
            end
          end
          WAIT_TX: begin
            // A tx_valid on the final allowed cycle still wins over the timeout.
            if (tx_valid_i) begin
              state_q <= SEND;
            end else if (to_cnt_q == TO_CNT_W'(TX_TIMEOUT - 1)) begin
              frame_err_o <= 1'b1;
              state_q     <= FRAME_END;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
          end
          SEND: begin
            if (ser_done) begin
              rd_addr_seen_q <= 1'b0;
              state_q        <= FRAME_END;
            end
          end
          FRAME_END: begin
            if (ss_n_i) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  spi_tx_serializer #(
    .DATA_W (DATA_W)
  ) u_tx_ser (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ser_load),
    .data_i     (tx_data_i),
    .shift_en_i (ser_shift),
    .miso_o     (ser_miso),
    .done_o     (ser_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_param
// Description : Self-checking bench for spi_slave_param (DATA_W=8 and 16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_param;

  localparam int TO = 16;

  typedef struct {
    bit         sel;
    logic [1:0] ctrl;
    logic [7:0] payload;
    int         abort_at;   // shift bits sent before ss_n rises; -1 = full frame
    int         tx_delay;   // WAIT_TX cycles before tx_valid; -1 = never
    logic [7:0] tx_data;
    int         exp_rv;     // expected rx_valid pulses for the frame
    int         exp_fe;     // expected frame_err pulses for the frame
  } frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DATA_W = 8 instance
  logic        rst8 = 1'b1, ss_n8 = 1'b1, mosi8 = 1'b0, tx_valid8 = 1'b0;
  logic [7:0]  tx_data8 = '0;
  logic        miso8, rx_valid8, frame_err8, busy8;
  logic [9:0]  rx_data8;

  // DATA_W = 16 instance
  logic        rst16 = 1'b1, ss_n16 = 1'b1, mosi16 = 1'b0, tx_valid16 = 1'b0;
  logic [15:0] tx_data16 = '0;
  logic        miso16, rx_valid16, frame_err16, busy16;
  logic [17:0] rx_data16;

  spi_slave_param #(.DATA_W(8), .TX_TIMEOUT(TO)) dut8 (
    .clk(clk), .rst(rst8), .ss_n_i(ss_n8), .mosi_i(mosi8), .miso_o(miso8),
    .rx_data_o(rx_data8), .rx_valid_o(rx_valid8), .tx_data_i(tx_data8),
    .tx_valid_i(tx_valid8), .frame_err_o(frame_err8), .busy_o(busy8));

  spi_slave_param #(.DATA_W(16), .TX_TIMEOUT(TO)) dut16 (
    .clk(clk), .rst(rst16), .ss_n_i(ss_n16), .mosi_i(mosi16), .miso_o(miso16),
    .rx_data_o(rx_data16), .rx_valid_o(rx_valid16), .tx_data_i(tx_data16),
    .tx_valid_i(tx_valid16), .frame_err_o(frame_err16), .busy_o(busy16));

  int n_vec = 0;
  int n_err = 0;
  int rv_cnt = 0;
  int fe_cnt = 0;

  // Frame-level reference state
  logic [9:0] m_rx = '0;
  bit         m_rd_seen = 1'b0;

  always @(negedge clk) begin
    if (rx_valid8)  rv_cnt++;
    if (frame_err8) fe_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Legal ctrl given sel and whether an RD_ADDR is outstanding.
  function automatic bit model_ok(input bit sel, input logic [1:0] ctrl);
    if (!sel)      return ctrl[1] == 1'b0;
    if (m_rd_seen) return ctrl == 2'b11;
    return ctrl == 2'b10;
  endfunction

  task automatic run8(input frame_t f);
    logic [9:0] word;
    bit ok, rdd, abort;
    int rv0, fe0;
    word  = {f.ctrl, f.payload};
    ok    = model_ok(f.sel, f.ctrl);
    rdd   = ok && f.sel && m_rd_seen;
    abort = (f.abort_at >= 0);
    rv0 = rv_cnt;
    fe0 = fe_cnt;
    ss_n8 = 1'b0; mosi8 = 1'b0; step();
    mosi8 = f.sel; step();
    for (int i = 0; i < 10; i++) begin
      if (abort && i == f.abort_at) break;
      mosi8 = word[9-i]; step();
    end
    if (abort) begin
      ss_n8 = 1'b1; step();
      check("abort_busy", busy8, 0);
    end else begin
      if (ok) begin
        m_rx = word;
        if (f.sel && !m_rd_seen) m_rd_seen = 1'b1;
      end
      if (rdd) begin
        if (f.tx_delay < 0) begin
          for (int k = 1; k <= TO; k++) begin
            step();
            check("wait_miso", miso8, 0);
            if (k >= TO - 1) check("timeout_edge", frame_err8, (k == TO));
          end
        end else begin
          for (int k = 0; k < f.tx_delay; k++) step();
          tx_valid8 = 1'b1; tx_data8 = f.tx_data; step();
          tx_valid8 = 1'b0; tx_data8 = 8'($urandom);
          for (int b = 0; b < 8; b++) begin
            check("miso_bit", miso8, f.tx_data[7-b]);
            step();
          end
          check("miso_after", miso8, 0);
          m_rd_seen = 1'b0;
        end
      end
      // Trailing MOSI bits in FRAME_END must be ignored.
      mosi8 = 1'($urandom); step();
      mosi8 = 1'($urandom); step();
      ss_n8 = 1'b1; step();
      check("end_busy", busy8, 0);
    end
    step();
    check("rx_valid_pulses", rv_cnt - rv0, f.exp_rv);
    check("frame_err_pulses", fe_cnt - fe0, f.exp_fe);
    check("rx_data", rx_data8, m_rx);
  endtask

  task automatic shift16(input bit sel, input logic [17:0] w);
    ss_n16 = 1'b0; mosi16 = 1'b0; step();
    mosi16 = sel; step();
    for (int i = 0; i < 18; i++) begin
      mosi16 = w[17-i]; step();
    end
  endtask

  frame_t tbl[15];
  frame_t fr;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b0, 2'b00, 8'h0A, -1,  0, 8'h00, 1, 0};
    tbl[1]  = '{1'b0, 2'b01, 8'h55, -1,  0, 8'h00, 1, 0};
    tbl[2]  = '{1'b1, 2'b10, 8'h0A, -1,  0, 8'h00, 1, 0};
    tbl[3]  = '{1'b1, 2'b11, 8'h0A, -1,  2, 8'h55, 1, 0};
    tbl[4]  = '{1'b0, 2'b01, 8'h33,  5,  0, 8'h00, 0, 1};
    tbl[5]  = '{1'b1, 2'b10, 8'h44, -1,  0, 8'h00, 1, 0};
    tbl[6]  = '{1'b1, 2'b11, 8'h44, -1, -1, 8'h00, 1, 1};
    tbl[7]  = '{1'b1, 2'b11, 8'h12, -1,  0, 8'hC3, 1, 0};
    tbl[8]  = '{1'b0, 2'b11, 8'h99, -1,  0, 8'h00, 0, 1};
    tbl[9]  = '{1'b1, 2'b11, 8'h77, -1,  0, 8'h00, 0, 1};
    tbl[10] = '{1'b1, 2'b10, 8'hFF, -1,  0, 8'h00, 1, 0};
    tbl[11] = '{1'b1, 2'b10, 8'h01, -1,  0, 8'h00, 0, 1};
    tbl[12] = '{1'b1, 2'b11, 8'hAB, -1, 15, 8'h81, 1, 0};
    tbl[13] = '{1'b0, 2'b00, 8'h00,  0,  0, 8'h00, 0, 1};
    tbl[14] = '{1'b0, 2'b01, 8'hF0,  9,  0, 8'h00, 0, 1};

    // Reset values
    step(); step();
    check("rst_miso", miso8, 0);
    check("rst_rx_data", rx_data8, 0);
    check("rst_rx_valid", rx_valid8, 0);
    check("rst_frame_err", frame_err8, 0);
    check("rst_busy", busy8, 0);
    rst8 = 1'b0; rst16 = 1'b0;
    step();

    foreach (tbl[i]) run8(tbl[i]);

    // Randomized frames scored by the frame-level model
    for (int n = 0; n < 40; n++) begin
      bit ok, rdd, abort;
      fr.sel     = 1'($urandom);
      if ($urandom_range(0, 3) != 0)
        fr.ctrl = fr.sel ? (m_rd_seen ? 2'b11 : 2'b10) : {1'b0, 1'($urandom)};
      else
        fr.ctrl = 2'($urandom);
      fr.payload  = 8'($urandom);
      fr.abort_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 9)) : -1;
      fr.tx_delay = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO - 1));
      fr.tx_data  = 8'($urandom);
      ok    = model_ok(fr.sel, fr.ctrl);
      rdd   = ok && fr.sel && m_rd_seen;
      abort = (fr.abort_at >= 0);
      fr.exp_rv = (!abort && ok) ? 1 : 0;
      fr.exp_fe = abort ? 1 : (!ok ? 1 : ((rdd && fr.tx_delay < 0) ? 1 : 0));
      run8(fr);
    end

    // DATA_W = 16: address read, data read, then reset during SEND
    shift16(1'b1, {2'b10, 16'hBEEF});
    check("w16_rv_addr", rx_valid16, 1);
    check("w16_rx_addr", rx_data16, 18'h2BEEF);
    ss_n16 = 1'b1; step();
    shift16(1'b1, {2'b11, 16'h0000});
    check("w16_rv_data", rx_valid16, 1);
    step();
    tx_valid16 = 1'b1; tx_data16 = 16'hA5C3; step();
    tx_valid16 = 1'b0; tx_data16 = 16'h0000;
    for (int b = 0; b < 16; b++) begin
      logic [15:0] exp_w;
      exp_w = 16'hA5C3;
      check("w16_miso_bit", miso16, exp_w[15-b]);
      step();
    end
    check("w16_miso_after", miso16, 0);
    ss_n16 = 1'b1; step();
    check("w16_busy_end", busy16, 0);

    shift16(1'b1, {2'b10, 16'h1234});
    ss_n16 = 1'b1; step();
    shift16(1'b1, {2'b11, 16'h1234});
    tx_valid16 = 1'b1; tx_data16 = 16'hFFFF; step();
    tx_valid16 = 1'b0;
    check("w16_send_bit0", miso16, 1);
    step(); step();
    rst16 = 1'b1; #1;
    check("w16_rst_miso", miso16, 0);
    check("w16_rst_busy", busy16, 0);
    check("w16_rst_rx_data", rx_data16, 0);
    check("w16_rst_rx_valid", rx_valid16, 0);
    check("w16_rst_frame_err", frame_err16, 0);
    ss_n16 = 1'b1;
    step();
    rst16 = 1'b0;
    step();
    // rd_addr_seen cleared by reset, so ctrl 11 lands in READ_ADD and is illegal.
    shift16(1'b1, {2'b11, 16'h5555});
    check("w16_post_rst_err", frame_err16, 1);
    check("w16_post_rst_rv", rx_valid16, 0);
    ss_n16 = 1'b1; step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
